// File: rtl/delay_sched_pkg.sv
// delay_sched_pkg: default sizing and tag-width helper for the delay line scheduler
package delay_sched_pkg;

    localparam int DEF_ELEMENT_WIDTH = 64;
    localparam int DEF_NUM_REQ       = 8;
    localparam int DEF_DELAY         = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEF_TAG_WIDTH = clog2(DEF_NUM_REQ);

endpackage

// File: rtl/delay_line_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin search starting at ptr, wrapping modulo NUM_REQ
module rr_arbiter import delay_sched_pkg::*; #(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int TAG_WIDTH = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [TAG_WIDTH-1:0] ptr,
    input  logic                 enable,
    output logic [NUM_REQ-1:0]   grant,
    output logic [TAG_WIDTH-1:0] idx
);

    logic                 hit;
    logic [TAG_WIDTH-1:0] j;

    // first requester at or after ptr wins; only indices below NUM_REQ are ever visited
    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        j     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = TAG_WIDTH'((int'(ptr) + k) % NUM_REQ);
            if (!hit && req[j]) begin
                hit = 1'b1;
                idx = j;
            end
        end
        grant[idx] = enable && hit;
    end

endmodule

// File: rtl/delay_line_scheduler.sv
// delay_line_scheduler: shares one fixed-latency element pipeline among round-robin arbitrated requesters
module delay_line_scheduler import delay_sched_pkg::*; #(
    parameter int ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int NUM_REQ       = DEF_NUM_REQ,
    parameter int DELAY         = DEF_DELAY,
    parameter int TAG_WIDTH     = clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ELEMENT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             out_valid,
    output logic [ELEMENT_WIDTH-1:0]         out_data,
    output logic [TAG_WIDTH-1:0]             out_tag,
    input  logic                             out_ready,
    output logic [3:0]                       inflight,
    output logic                             idle
);

    logic [DELAY-1:0]         sv;
    logic [ELEMENT_WIDTH-1:0] sd [DELAY];
    logic [TAG_WIDTH-1:0]     st [DELAY];
    logic [TAG_WIDTH-1:0]     ptr;
    logic [TAG_WIDTH-1:0]     idx;
    logic [ELEMENT_WIDTH-1:0] sel_data;
    logic                     advance;
    logic                     accept;
    logic                     pop;

    assign out_valid = sv[DELAY-1];
    assign out_data  = sd[DELAY-1];
    assign out_tag   = st[DELAY-1];
    assign advance   = !out_valid || out_ready;
    assign accept    = |(req_valid & req_ready);
    assign pop       = out_valid && out_ready;
    assign idle      = (inflight == 4'd0) && !(|req_valid);

    // grants are suppressed while reset is held so nothing looks accepted during reset
    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .enable (advance && rst_n),
        .grant  (req_ready),
        .idx    (idx)
    );

    // select the granted lane's data; zero when nothing is granted
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i]) sel_data = req_data[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
    end

    // whole pipe shifts on advance and holds completely otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sv <= '0;
            for (int i = 0; i < DELAY; i++) begin
                sd[i] <= '0;
                st[i] <= '0;
            end
        end else if (advance) begin
            sv[0] <= accept;
            sd[0] <= sel_data;
            st[0] <= idx;
            for (int i = 1; i < DELAY; i++) begin
                sv[i] <= sv[i-1];
                sd[i] <= sd[i-1];
                st[i] <= st[i-1];
            end
        end
    end

    // round-robin pointer moves just past the lane that was accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else if (accept) ptr <= (idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end

    // occupancy tracks stage valids: accepts enter, pops leave
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= '0;
        else if (accept && !pop) inflight <= inflight + 4'd1;
        else if (pop && !accept) inflight <= inflight - 4'd1;
    end

endmodule

// File: tb/tb_delay_line_scheduler.sv
// tb_delay_line_scheduler: directed scoreboard bench for delay_line_scheduler
module tb_delay_line_scheduler;

    localparam int EW = 64;
    localparam int NR = 8;
    localparam int DL = 2;
    localparam int TW = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*EW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              out_valid;
    logic [EW-1:0]     out_data;
    logic [TW-1:0]     out_tag;
    logic              out_ready;
    logic [3:0]        inflight;
    logic              idle;

    int                tests = 0;
    int                failed = 0;
    logic [DL-1:0]     mv;
    int                mptr;
    logic [TW+EW-1:0]  sb [$];

    always #5 clk = ~clk;

    delay_line_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ready (out_ready),
        .inflight  (inflight),
        .idle      (idle)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int winner(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++)
            if (v[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic set_lane(input int i, input logic [EW-1:0] v);
        req_data[i*EW +: EW] = v;
    endtask

    task automatic model_reset();
        mv   = '0;
        mptr = 0;
        sb.delete();
    endtask

    // one clock: compare against the model, advance the model, then cross the edge
    task automatic cycle();
        int            w;
        logic          ov;
        logic          adv;
        logic          acc;
        logic [NR-1:0] er;
        #1;
        ov  = mv[DL-1];
        adv = !ov || out_ready;
        w   = winner(req_valid, mptr);
        acc = adv && (w >= 0);
        er  = acc ? (NR'(1) << w) : '0;
        check("req_ready", 64'(req_ready), 64'(er));
        check("out_valid", 64'(out_valid), 64'(ov));
        if (ov) begin
            check("out_tag", 64'(out_tag), 64'(sb[0][TW+EW-1:EW]));
            check("out_data", out_data, sb[0][EW-1:0]);
        end
        check("inflight", 64'(inflight), 64'($countones(mv)));
        check("idle", 64'(idle), 64'(($countones(mv) == 0) && (req_valid == '0)));
        if (ov && out_ready) void'(sb.pop_front());
        if (adv) mv = {mv[DL-2:0], acc};
        if (acc) begin
            sb.push_back({TW'(w), req_data[w*EW +: EW]});
            mptr = (w + 1) % NR;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 8'hFF;
        out_ready = 1'b1;
        req_data  = '0;
        for (int i = 0; i < NR; i++) set_lane(i, 64'(i + 100));
        model_reset();

        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1;
            check("rst_req_ready", 64'(req_ready), 64'h0);
            check("rst_out_valid", 64'(out_valid), 64'h0);
            check("rst_out_data", out_data, 64'h0);
            check("rst_inflight", 64'(inflight), 64'h0);
        end

        rst_n = 1'b1;
        #1;
        check("first_grant_lane0", 64'(req_ready), 64'h01);
        for (int c = 0; c < 10; c++) cycle();
        req_valid = '0;
        for (int c = 0; c < 3; c++) cycle();

        req_valid = 8'h20;
        for (int c = 0; c < 4; c++) begin
            set_lane(5, 64'(4'hA + c));
            cycle();
        end
        req_valid = 8'h88;
        set_lane(3, 64'h33);
        set_lane(7, 64'h77);
        #1;
        check("sparse_grant_7", 64'(req_ready), 64'h80);
        cycle();
        #1;
        check("sparse_grant_3", 64'(req_ready), 64'h08);
        cycle();
        req_valid = '0;
        for (int c = 0; c < 3; c++) cycle();

        req_valid = 8'hFF;
        for (int i = 0; i < NR; i++) set_lane(i, 64'(i + 200));
        for (int c = 0; c < 3; c++) cycle();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("stall_req_ready", 64'(req_ready), 64'h0);
            check("stall_inflight", 64'(inflight), 64'd2);
            cycle();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        req_valid = '0;
        for (int c = 0; c < 3; c++) cycle();

        req_valid = 8'hFF;
        for (int i = 0; i < NR; i++) set_lane(i, 64'(i + 300));
        for (int c = 0; c < 3; c++) cycle();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'h0);
        check("midrst_inflight", 64'(inflight), 64'h0);
        check("midrst_req_ready", 64'(req_ready), 64'h0);
        model_reset();
        req_valid = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_idle", 64'(idle), 64'h1);
        for (int c = 0; c < 4; c++) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
